// File: rtl/step_rate_meter.sv
// Measures the period of an external step pulse train and converts it to a speed
// word floor(K / period). Reports 0 and raises stalled when no edge arrives within K clocks.
//
// state  | meaning
// IDLE   | no reference edge yet; next rising edge arms the period counter
// ARMED  | counting clocks since the last edge; next edge captures a period
// DIVIDE | restoring divide K/period, one quotient bit per clock (first cycle may load a pending period)
// DONE   | publish quotient; continue with pending period or return to ARMED
module step_rate_meter #(
    parameter int SPEED_W  = 28,
    parameter int PERIOD_W = 28,
    parameter int K        = 5000000,
    parameter int SYNC     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stepIn,
    output logic [SPEED_W-1:0] speed,
    output logic               speedValid,
    output logic               stalled,
    output logic               busy
);

    localparam int IW = $clog2(PERIOD_W + 1);
    localparam logic [PERIOD_W-1:0] K_P     = PERIOD_W'(K);
    localparam logic [PERIOD_W-1:0] K_P1    = PERIOD_W'(K + 1);
    localparam logic [IW-1:0]       LAST_IT = IW'(PERIOD_W - 1);
    localparam logic [63:0]         SPD_MAX = (64'd1 << SPEED_W) - 64'd1;

    typedef enum logic [1:0] {IDLE, ARMED, DIVIDE, DONE} state_t;

    state_t              state_q, state_d;
    logic [SYNC-1:0]     sync_q, sync_d;
    logic                lvl_q, lvl_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic                to_q, to_d;
    logic                load_q, load_d;
    logic [PERIOD_W-1:0] dvd_q, dvd_d;
    logic [PERIOD_W-1:0] rem_q, rem_d;
    logic [PERIOD_W-1:0] dsr_q, dsr_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic                speed_valid_q, speed_valid_d;
    logic                stalled_q, stalled_d;

    logic                step_edge, period_ok, to_now;
    logic [PERIOD_W:0]   rem_sh, diff;
    logic [63:0]         quot64;

    always_comb begin
        sync_d        = {sync_q[SYNC-2:0], stepIn};
        lvl_d         = sync_q[SYNC-1];
        step_edge     = sync_q[SYNC-1] & ~lvl_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        to_d          = to_q;
        load_d        = load_q;
        dvd_d         = dvd_q;
        rem_d         = rem_q;
        dsr_d         = dsr_q;
        iter_d        = iter_q;
        speed_d       = speed_q;
        speed_valid_d = 1'b0;
        stalled_d     = stalled_q;
        quot64        = 64'(dvd_q);

        // Counter restarts on every edge and parks at K+1; zero means no reference edge yet.
        if (step_edge)
            cnt_d = PERIOD_W'(1);
        else if (cnt_q != '0 && cnt_q != K_P1)
            cnt_d = cnt_q + PERIOD_W'(1);

        period_ok = step_edge && (cnt_q != '0) && (cnt_q <= K_P);
        to_now    = !step_edge && (cnt_q == K_P);

        rem_sh = {rem_q, dvd_q[PERIOD_W-1]};
        diff   = rem_sh - {1'b0, dsr_q};

        if ((state_q == DIVIDE || state_q == DONE) && to_now)
            to_d = 1'b1;
        if (period_ok && (state_q == DONE || (state_q == DIVIDE && !load_q))) begin
            pend_d       = cnt_q;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (step_edge)
                    state_d = ARMED;
            end
            ARMED: begin
                if (to_q || to_now) begin
                    speed_d       = '0;
                    speed_valid_d = 1'b1;
                    stalled_d     = 1'b1;
                    to_d          = 1'b0;
                    pend_valid_d  = 1'b0;
                    if (!step_edge && (to_now || cnt_q == K_P1))
                        state_d = IDLE;
                end else if (period_ok) begin
                    dvd_d   = K_P;
                    rem_d   = '0;
                    dsr_d   = cnt_q;
                    iter_d  = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (load_q) begin
                    dvd_d        = K_P;
                    rem_d        = '0;
                    dsr_d        = period_ok ? cnt_q : pend_q;
                    iter_d       = '0;
                    pend_valid_d = 1'b0;
                    load_d       = 1'b0;
                end else begin
                    rem_d  = diff[PERIOD_W] ? rem_sh[PERIOD_W-1:0] : diff[PERIOD_W-1:0];
                    dvd_d  = {dvd_q[PERIOD_W-2:0], ~diff[PERIOD_W]};
                    iter_d = iter_q + IW'(1);
                    if (iter_q == LAST_IT)
                        state_d = DONE;
                end
            end
            DONE: begin
                speed_d       = (quot64 > SPD_MAX) ? SPEED_W'(SPD_MAX) : SPEED_W'(quot64);
                speed_valid_d = 1'b1;
                stalled_d     = 1'b0;
                // An owed timeout is published from ARMED before any pending period.
                if (to_d)
                    state_d = ARMED;
                else if (pend_valid_q || period_ok) begin
                    state_d = DIVIDE;
                    load_d  = 1'b1;
                end else
                    state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            lvl_q         <= 1'b0;
            cnt_q         <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            to_q          <= 1'b0;
            load_q        <= 1'b0;
            dvd_q         <= '0;
            rem_q         <= '0;
            dsr_q         <= '0;
            iter_q        <= '0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            stalled_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            lvl_q         <= lvl_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            to_q          <= to_d;
            load_q        <= load_d;
            dvd_q         <= dvd_d;
            rem_q         <= rem_d;
            dsr_q         <= dsr_d;
            iter_q        <= iter_d;
            speed_q       <= speed_d;
            speed_valid_q <= speed_valid_d;
            stalled_q     <= stalled_d;
        end
    end

    assign speed      = speed_q;
    assign speedValid = speed_valid_q;
    assign stalled    = stalled_q;
    assign busy       = (state_q == DIVIDE) || (state_q == DONE);

endmodule
